// File: rtl/add_pipe_seg_pkg.sv
// Shared configuration for the segmented pipelined adder: default sizes and
// helpers deriving the segment width and validating the split.
package add_pipe_seg_pkg;

  localparam int DEF_W    = 64;
  localparam int DEF_NSEG = 4;

  function automatic bit seg_cfg_ok(input int w, input int nseg);
    return (nseg >= 1) && (nseg <= w) && ((w % nseg) == 0);
  endfunction

  function automatic int seg_width(input int w, input int nseg);
    return (nseg >= 1) ? (w / nseg) : w;
  endfunction

endpackage

// File: rtl/add_pipe_seg_if.sv
// Operand/result stream bundle for add_pipe_seg; the sub field exists only
// when ADD_PIPE_SUB_EN is defined.
interface add_pipe_seg_if
  import add_pipe_seg_pkg::*;
#(
  parameter int W = DEF_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef ADD_PIPE_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef ADD_PIPE_SUB_EN
           sub,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef ADD_PIPE_SUB_EN
           sub,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/add_pipe_seg_stage.sv
// One carry segment: SW-bit adder with registered sum, carry-out and valid,
// updated only while the pipe advances.
module add_pipe_stage #(
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          vld_i,
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          c_i,
  output logic [SW-1:0] sum_o,
  output logic          c_o,
  output logic          vld_o
);
  logic [SW:0]   res_d;
  logic [SW-1:0] sum_q;
  logic          c_q;
  logic          vld_q;

  assign res_d = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, c_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      c_q   <= 1'b0;
      vld_q <= 1'b0;
    end else if (en_i) begin
      sum_q <= res_d[SW-1:0];
      c_q   <= res_d[SW];
      vld_q <= vld_i;
    end
  end

  assign sum_o = sum_q;
  assign c_o   = c_q;
  assign vld_o = vld_q;
endmodule

// File: rtl/add_pipe_seg.sv
// W-bit adder pipelined as NSEG carry segments, latency NSEG, whole pipe freezes on stall.
// ADD_PIPE_SUB_EN adds a captured sub select computing a - b (cout = ~borrow).
module add_pipe_seg
  import add_pipe_seg_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int NSEG = DEF_NSEG
) (
  input  logic          clk,
  input  logic          rst,
  add_pipe_seg_if.slave bus
);
  localparam int SW = seg_width(W, NSEG);

  if (!seg_cfg_ok(W, NSEG)) begin : g_cfg_err
    $error("add_pipe_seg: W must be a multiple of NSEG with 1 <= NSEG <= W");
  end

  logic         adv;
  logic         c0;
  logic [W-1:0] b_in;

  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

`ifdef ADD_PIPE_SUB_EN
  // Inverting b once at entry lets the skewed upper segments carry it already inverted.
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign c0   = bus.sub | bus.cin;
`else
  assign b_in = bus.b;
  assign c0   = bus.cin;
`endif

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [SW-1:0]       a_seg;
    logic [SW-1:0]       b_seg;
    logic [SW-1:0]       s_seg;
    logic                c_seg;
    logic                v_seg;
    logic                c_out;
    logic                v_out;
    logic [(k+1)*SW-1:0] done;

    if (k == 0) begin : g_in
      assign a_seg = bus.a[SW-1:0];
      assign b_seg = b_in[SW-1:0];
      assign c_seg = c0;
      assign v_seg = bus.in_valid;
      assign done  = s_seg;
    end else begin : g_in
      logic [k*SW-1:0] lo_d;
      logic [k*SW-1:0] lo_q;

      assign a_seg = g_seg[k-1].g_skew.a_rem_q[SW-1:0];
      assign b_seg = g_seg[k-1].g_skew.b_rem_q[SW-1:0];
      assign c_seg = g_seg[k-1].c_out;
      assign v_seg = g_seg[k-1].v_out;
      assign lo_d  = g_seg[k-1].done;
      assign done  = {s_seg, lo_q};

      // Finished lower segments ride along so the whole sum leaves in one cycle.
      always_ff @(posedge clk) begin
        if (rst)      lo_q <= '0;
        else if (adv) lo_q <= lo_d;
      end
    end

    if (k < NSEG-1) begin : g_skew
      localparam int RW = W - (k+1)*SW;
      logic [RW-1:0] a_rem_d;
      logic [RW-1:0] b_rem_d;
      logic [RW-1:0] a_rem_q;
      logic [RW-1:0] b_rem_q;

      if (k == 0) begin : g_src
        assign a_rem_d = bus.a[W-1:SW];
        assign b_rem_d = b_in[W-1:SW];
      end else begin : g_src
        assign a_rem_d = g_seg[k-1].g_skew.a_rem_q[RW+SW-1:SW];
        assign b_rem_d = g_seg[k-1].g_skew.b_rem_q[RW+SW-1:SW];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (adv) begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end

    add_pipe_stage #(.SW(SW)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en_i  (adv),
      .vld_i (v_seg),
      .a_i   (a_seg),
      .b_i   (b_seg),
      .c_i   (c_seg),
      .sum_o (s_seg),
      .c_o   (c_out),
      .vld_o (v_out)
    );
  end

  assign bus.sum       = g_seg[NSEG-1].done;
  assign bus.cout      = g_seg[NSEG-1].c_out;
  assign bus.out_valid = g_seg[NSEG-1].v_out;
endmodule
